bcd_serial_adder: RTL and testbench

// - Digit-serial multi-digit BCD adder. Consumes two packed BCD operands and adds one

---
 rtl/bcd_serial_adder_pkg.sv | 16 +
 rtl/bcd_digit_add.sv | 33 +++
 rtl/bcd_serial_adder.sv | 129 ++++++++++++
 tb/tb_bcd_serial_adder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_serial_adder_pkg.sv
// Shared definitions for the digit-serial BCD adder.
// - state_t : FSM state encoding (IDLE, ADD, DONE)
// - BCD_MAX : largest legal BCD digit value
// - BCD_ADJ : correction added to a binary digit sum that exceeds BCD_MAX
package bcd_serial_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;
    localparam logic [3:0] BCD_ADJ = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// One decimal digit step: 4-bit binary add with carry-in, then the +6 BCD correction.
// Ports:
// - a, b   : operand digits (may be illegal, i.e. >9)
// - cin    : decimal carry in
// - digit  : corrected BCD digit
// - cout   : decimal carry out
// - bad    : either operand digit is above 9
module bcd_digit_add
    import bcd_serial_adder_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] digit,
    output logic       cout,
    output logic       bad
);

    logic [4:0] s;

    always_comb begin
        s     = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        digit = s[3:0];
        cout  = 1'b0;
        // Sums 10..19 wrap to the right decimal digit after adding 6 mod 16.
        if (s > {1'b0, BCD_MAX}) begin
            digit = s[3:0] + BCD_ADJ;
            cout  = 1'b1;
        end
        bad = (a > BCD_MAX) | (b > BCD_MAX);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial multi-digit BCD adder, one digit per clock, LSD first.
// Ports:
// - Clk, Reset : clock, asynchronous active-high reset
// - Start      : request a new add (taken only when idle or done)
// - A, B       : packed BCD operands, digit 0 in bits [3:0]
// - Busy       : high while digits are being added
// - Done       : one-cycle pulse when Sum/Cout/Invalid are updated
// - Sum, Cout  : packed BCD result and decimal carry out, held between completions
// - Invalid    : some operand digit of the last operation was above 9
module bcd_serial_adder
    import bcd_serial_adder_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Start,
    input  logic [4*DIGITS-1:0] A,
    input  logic [4*DIGITS-1:0] B,
    output logic                Busy,
    output logic                Done,
    output logic [4*DIGITS-1:0] Sum,
    output logic                Cout,
    output logic                Invalid
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(DIGITS + 1);

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d;
    logic [W-1:0]   res_q, res_d;
    logic [W-1:0]   sum_q, sum_d;
    logic           carry_q, carry_d;
    logic           inv_q, inv_d;
    logic           cout_q, cout_d;
    logic           invalid_q, invalid_d;

    logic [3:0]     dig;
    logic           dig_cout;
    logic           dig_bad;

    bcd_digit_add u_digit (
        .a     (a_q[3:0]),
        .b     (b_q[3:0]),
        .cin   (carry_q),
        .digit (dig),
        .cout  (dig_cout),
        .bad   (dig_bad)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            sum_q     <= '0;
            carry_q   <= 1'b0;
            inv_q     <= 1'b0;
            cout_q    <= 1'b0;
            invalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            sum_q     <= sum_d;
            carry_q   <= carry_d;
            inv_q     <= inv_d;
            cout_q    <= cout_d;
            invalid_q <= invalid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        sum_d     = sum_q;
        carry_d   = carry_q;
        inv_d     = inv_q;
        cout_d    = cout_q;
        invalid_d = invalid_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (Start) begin
                    a_d     = A;
                    b_d     = B;
                    res_d   = '0;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    inv_d   = 1'b0;
                    state_d = ST_ADD;
                end
            end
            ST_ADD: begin
                // New digit enters at the top; after DIGITS steps digit 0 sits at the bottom.
                res_d   = W'({dig, res_q} >> 4);
                a_d     = a_q >> 4;
                b_d     = b_q >> 4;
                carry_d = dig_cout;
                inv_d   = inv_q | dig_bad;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CW'(DIGITS - 1)) begin
                    sum_d     = res_d;
                    cout_d    = dig_cout;
                    invalid_d = inv_q | dig_bad;
                    state_d   = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy    = (state_q == ST_ADD);
    assign Done    = (state_q == ST_DONE);
    assign Sum     = sum_q;
    assign Cout    = cout_q;
    assign Invalid = invalid_q;

endmodule

// File: tb/tb_bcd_serial_adder.sv
module tb_bcd_serial_adder;

    localparam int D = 4;
    localparam int W = 4 * D;

    logic         Clk   = 1'b0;
    logic         Reset = 1'b1;
    logic         Start = 1'b0;
    logic [W-1:0] A     = '0;
    logic [W-1:0] B     = '0;
    logic         Busy, Done, Cout, Invalid;
    logic [W-1:0] Sum;

    int checks = 0;
    int errors = 0;

    bcd_serial_adder #(.DIGITS(D)) dut (
        .Clk     (Clk),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .Busy    (Busy),
        .Done    (Done),
        .Sum     (Sum),
        .Cout    (Cout),
        .Invalid (Invalid)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (decimal arithmetic) ----------------
    function automatic int bcd_val(input logic [W-1:0] v);
        int r = 0;
        int p = 1;
        for (int d = 0; d < D; d++) begin
            r += int'(v[4*d +: 4]) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic bit bcd_bad(input logic [W-1:0] v);
        for (int d = 0; d < D; d++)
            if (v[4*d +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int x);
        logic [W-1:0] r = '0;
        for (int d = 0; d < D; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    int           rem       = 0;
    bit           e_done    = 0;
    bit           e_inv     = 0;
    bit           e_cout    = 0;
    logic [W-1:0] e_sum     = '0;
    bit           sum_known = 1;
    bit           p_inv, p_cout;
    logic [W-1:0] p_sum;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rem = 0; e_done = 0; e_inv = 0; e_cout = 0; e_sum = '0; sum_known = 1;
        end else begin
            e_done = 0;
            if (rem > 0) begin
                rem--;
                if (rem == 0) begin
                    e_done = 1; e_inv = p_inv; e_sum = p_sum; e_cout = p_cout;
                    sum_known = !p_inv;
                end
            end else if (Start) begin
                int tot;
                tot    = bcd_val(A) + bcd_val(B);
                p_inv  = bcd_bad(A) | bcd_bad(B);
                p_sum  = to_bcd(tot);
                p_cout = (tot >= 10 ** D);
                rem    = D;
            end
        end
    end

    // Per-cycle compare of DUT against the model.
    always @(posedge Clk) begin
        #1;
        chk("busy", 32'(Busy), 32'(rem > 0));
        chk("done", 32'(Done), 32'(e_done));
        chk("invalid", 32'(Invalid), 32'(e_inv));
        if (sum_known) begin
            chk("sum", 32'(Sum), 32'(e_sum));
            chk("cout", 32'(Cout), 32'(e_cout));
        end
    end

    // ---------------- directed helpers ----------------
    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] r;
        for (int d = 0; d < D; d++)
            r[4*d +: 4] = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(10, 15))
                                                       : 4'($urandom_range(0, 9));
        return r;
    endfunction

    task automatic run_op(input string nm, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] es, input bit ec, input bit ei, input bit cs);
        int cnt = 0;
        @(negedge Clk);
        A = a; B = b; Start = 1'b1;
        while (cnt < 20) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            cnt++;
            if (Done) break;
        end
        chk({nm, "_latency"}, cnt, D + 1);
        chk({nm, "_inv"}, 32'(Invalid), 32'(ei));
        if (cs) begin
            chk({nm, "_sum"}, 32'(Sum), 32'(es));
            chk({nm, "_cout"}, 32'(Cout), 32'(ec));
        end
    endtask

    initial begin
        int cnt;
        repeat (2) @(posedge Clk);
        #1;
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_sum", 32'(Sum), 0);
        chk("rst_cout", 32'(Cout), 0);
        chk("rst_inv", 32'(Invalid), 0);
        @(negedge Clk);
        Reset = 1'b0;

        run_op("t1", 16'h0006, 16'h0006, 16'h0012, 1'b0, 1'b0, 1'b1);
        run_op("t2a", 16'h0002, 16'h0003, 16'h0005, 1'b0, 1'b0, 1'b1);
        run_op("t2b", 16'h0008, 16'h0002, 16'h0010, 1'b0, 1'b0, 1'b1);
        run_op("t3a", 16'h9999, 16'h0001, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("t3b", 16'h9999, 16'h9999, 16'h9998, 1'b1, 1'b0, 1'b1);
        run_op("t3c", 16'h1909, 16'h0191, 16'h2100, 1'b0, 1'b0, 1'b1);
        run_op("t4a", 16'h000A, 16'h0001, 16'h0000, 1'b0, 1'b1, 1'b0);
        run_op("t4b", 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1);

        // Reset in the middle of an add.
        @(negedge Clk);
        A = 16'h5555; B = 16'h4444; Start = 1'b1;
        @(posedge Clk); #1; Start = 1'b0;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("t6_busy", 32'(Busy), 0);
        chk("t6_done", 32'(Done), 0);
        chk("t6_sum", 32'(Sum), 0);
        chk("t6_cout", 32'(Cout), 0);
        chk("t6_inv", 32'(Invalid), 0);
        @(negedge Clk);
        Reset = 1'b0;
        run_op("t6_after", 16'h4321, 16'h1234, 16'h5555, 1'b0, 1'b0, 1'b1);

        // Start held through ADD with operands changing, then back-to-back.
        @(negedge Clk);
        A = 16'h1234; B = 16'h1111; Start = 1'b1;
        cnt = 0;
        while (cnt < 20) begin
            @(posedge Clk); #1;
            cnt++;
            if (Done) break;
            A = rand_bcd(); B = rand_bcd();
        end
        chk("t5_latency", cnt, D + 1);
        chk("t5_sum", 32'(Sum), 32'h2345);
        chk("t5_cout", 32'(Cout), 0);
        A = 16'h0500; B = 16'h0700;
        cnt = 0;
        while (cnt < 20) begin
            @(posedge Clk); #1;
            Start = 1'b0;
            cnt++;
            if (Done) break;
        end
        chk("t5_b2b_latency", cnt, D + 1);
        chk("t5_b2b_sum", 32'(Sum), 32'h1200);

        // Randomized traffic with one asynchronous reset in the middle.
        for (int i = 0; i < 1500; i++) begin
            @(negedge Clk);
            Start = ($urandom_range(0, 3) == 0);
            A = rand_bcd();
            B = rand_bcd();
            Reset = (i == 700);
        end
        @(negedge Clk);
        Start = 1'b0; Reset = 1'b0;
        repeat (10) @(posedge Clk);
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
